sar_conv_sequencer: RTL and testbench
=====================================

// Module: sar_conv_sequencer
// PURPOSE
//  Sequences the 8-bit SAR conversion core across up to NCH analog channels: selects the input mux channel,
//  holds a track/sample window, releases the SAR core from reset and waits for its done flag.
//  It captures the 8-bit result and presents it on a valid/ready result port with its channel tag.
//  Sits between system control (start/mask) and the SAR core, whose active-low reset is driven by sar_run.
// PARAMETERS
//  NCH         4   number of analog channels (2..8); CHW = $clog2(NCH) is a derived localparam
//  SAMPLE_CYC  4   cycles sample is held high before each conversion (1..15)
//  TIMEOUT     15  max CONVERT cycles without sar_done before abort (>=10)
// PORTS
//  clk          in   1    system clock; all logic on posedge
//  rst_n        in   1    asynchronous active-low reset
//  ena          in   1    design enable; low aborts to IDLE on next edge
//  start        in   1    begin a sweep (sampled in IDLE only)
//  continuous   in   1    1 = restart the sweep after last enabled channel
//  ch_mask      in   NCH  enabled channels; latched at each sweep start
//  sar_done     in   1    SAR core conversion complete
//  sar_result   in   8    SAR core result, valid while sar_done=1
//  sar_run      out  1    drives SAR core rst_n; 1 only in CONVERT
//  sample       out  1    track/hold control for the input mux
//  ch_sel       out  CHW  analog mux channel select
//  res_valid    out  1    result available
//  res_ready    in   1    consumer accepts result
//  res_data     out  8    captured conversion result
//  res_ch       out  CHW  channel of res_data
//  busy         out  1    state != IDLE
//  err_timeout  out  1    sticky; set on SAR timeout, cleared by accepted start
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; mask latch=0, counters=0. Reset mid-operation aborts at once.
//  - IDLE: start & ena & ch_mask!=0 -> latch mask, ch_sel = lowest set bit, clear err_timeout, go SAMPLE.
//    start with ch_mask==0 is ignored.
//  - SAMPLE: sample=1 for exactly SAMPLE_CYC cycles, ch_sel stable -> CONVERT (sample=0).
//  - CONVERT: sar_run=1, timeout counter counts from 0.
//    - sar_done=1: register res_data=sar_result, res_ch=ch_sel; sar_run=0 next cycle; go OUTPUT.
//    - Counter reaches TIMEOUT without done: err_timeout=1, sar_run=0, go IDLE; the sweep is abandoned.
//  - OUTPUT: res_valid=1; res_data/res_ch held stable until res_valid & res_ready.
//    On the handshake cycle, res_valid drops next cycle and the sequencer advances:
//    - Next set mask bit above ch_sel exists -> select it, go SAMPLE.
//    - Else, if continuous=1 (sampled on the handshake cycle) -> re-latch ch_mask, wrap to its lowest set bit, go SAMPLE.
//      If the new mask==0 -> IDLE.
//    - Else -> IDLE.
//  - Latency from start to first sample: 1 cycle. sample->sar_run: SAMPLE_CYC cycles.
//    sar_done->res_valid: 1 cycle.
//  - Backpressure: no new sample/convert begins while res_valid=1 and res_ready=0 (single result buffer).
//  - ena=0 in any state: next edge -> IDLE, sar_run=0, sample=0, res_valid=0; err_timeout keeps its value.
//  - start asserted while busy is ignored. Mid-sweep ch_mask changes are ignored until the next latch.
//  - ch_sel holds last value in IDLE; res_ch/res_data hold until next capture.
// TESTING
//  1. NCH=4, mask=4'b0101, single start, core model done after 9 cycles, res_ready=1 -> results ch0 then ch2;
//     sample high 4 cycles each; busy=0 after 2nd handshake.
//  2. res_ready held 0 for 10 cycles in OUTPUT -> res_valid stays 1, res_data/res_ch stable, sample/sar_run stay 0.
//  3. continuous=1, mask=4'b1000 -> repeated ch3 conversions. Drop continuous mid-conversion ->
//     exactly one more result, then IDLE.
//  4. sar_done tied 0 -> err_timeout=1 after 15 CONVERT cycles, sar_run=0, IDLE; next start clears err_timeout.
//  5. rst_n low during CONVERT -> sar_run, sample, res_valid, busy all 0 without a clock edge.
//     start with mask=0 -> busy stays 0.
//  6. ena low during SAMPLE -> IDLE next edge, no result produced; start with ena=0 ignored.

Source files
------------

// File: rtl/sar_conv_sequencer_if.sv
// sar_conv_sequencer_if: valid/ready result port carrying an 8-bit SAR result and its channel tag.
interface sar_conv_sequencer_if #(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);
    logic           valid;
    logic           ready;
    logic [7:0]     data;
    logic [CHW-1:0] ch;
    modport master (output valid, data, ch, input ready);
    modport slave  (input valid, data, ch, output ready);
endinterface

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: sweeps masked analog channels through sample/convert on an 8-bit SAR core
// and hands each result out on a single-entry valid/ready port.
module sar_conv_sequencer #(
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int TIMEOUT    = 15,
    localparam int CHW       = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [NCH-1:0]        ch_mask,
    input  logic                  sar_done,
    input  logic [7:0]            sar_result,
    output logic                  sar_run,
    output logic                  sample,
    output logic [CHW-1:0]        ch_sel,
    output logic                  busy,
    output logic                  err_timeout,
    sar_conv_sequencer_if.master  res
);
    localparam int CMAX = TIMEOUT > SAMPLE_CYC ? TIMEOUT : SAMPLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_OUTPUT} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [CHW-1:0] ch_d, rch_q, rch_d;
    logic [7:0]     data_q, data_d;
    logic           err_d;
    logic [CHW:0]   nxt, low;

    // {found, index} of the lowest set bit of m at or above position lo
    function automatic logic [CHW:0] first_from(input logic [NCH-1:0] m, input int lo);
        first_from = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i] && i >= lo) first_from = {1'b1, CHW'(i)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mask_q      <= '0;
            ch_sel      <= '0;
            rch_q       <= '0;
            data_q      <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            mask_q      <= mask_d;
            ch_sel      <= ch_d;
            rch_q       <= rch_d;
            data_q      <= data_d;
            err_timeout <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mask_d  = mask_q;
        ch_d    = ch_sel;
        rch_d   = rch_q;
        data_d  = data_q;
        err_d   = err_timeout;
        nxt     = first_from(mask_q, int'(ch_sel) + 1);
        low     = first_from(ch_mask, 0);
        if (!ena) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                S_IDLE:
                    if (start && low[CHW]) begin
                        mask_d  = ch_mask;
                        ch_d    = low[CHW-1:0];
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_SAMPLE;
                    end
                S_SAMPLE:
                    if (cnt == CW'(SAMPLE_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CONVERT;
                    end else cnt_d = cnt + CW'(1);
                S_CONVERT:
                    if (sar_done) begin
                        data_d  = sar_result;
                        rch_d   = ch_sel;
                        cnt_d   = '0;
                        state_d = S_OUTPUT;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else cnt_d = cnt + CW'(1);
                S_OUTPUT:
                    if (res.ready) begin
                        if (nxt[CHW]) begin
                            ch_d    = nxt[CHW-1:0];
                            state_d = S_SAMPLE;
                        end else if (continuous) begin
                            // wrap: fresh mask, and ch_sel keeps its value if nothing is enabled
                            mask_d  = ch_mask;
                            ch_d    = low[CHW] ? low[CHW-1:0] : ch_sel;
                            state_d = low[CHW] ? S_SAMPLE : S_IDLE;
                        end else state_d = S_IDLE;
                    end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sar_run   = state == S_CONVERT;
    assign sample    = state == S_SAMPLE;
    assign busy      = state != S_IDLE;
    assign res.valid = state == S_OUTPUT;
    assign res.data  = data_q;
    assign res.ch    = rch_q;
endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb_sar_conv_sequencer: randomized scenarios against a channel-list reference model and a
// behavioural SAR core that records every result it produces.
module tb_sar_conv_sequencer;
    localparam int NCH = 4, SAMPLE_CYC = 4, TIMEOUT = 15, CHW = 2;

    logic clk = 0, rst_n = 0, ena = 0, start = 0, continuous = 0;
    logic sar_done = 0, sar_run, sample, busy, err_timeout;
    logic [NCH-1:0] ch_mask = '0;
    logic [7:0] sar_result = '0;
    logic [CHW-1:0] ch_sel;

    int n_cmp = 0, n_fail = 0;
    int core_delay = 9, core_cnt = 0;
    bit core_en = 1, core_rand = 0;
    int got_ch[$], got_data[$], core_q[$], sample_runs[$];
    int srun = 0, run_starts = 0;
    logic run_prev = 0;

    sar_conv_sequencer_if #(.NCH(NCH)) res_if();

    sar_conv_sequencer #(.NCH(NCH), .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .sar_done(sar_done), .sar_result(sar_result), .sar_run(sar_run),
        .sample(sample), .ch_sel(ch_sel), .busy(busy), .err_timeout(err_timeout), .res(res_if.master)
    );

    always #5 clk = ~clk;

    // SAR core: raises done core_delay cycles into a run with a fresh random result
    always @(posedge clk or negedge rst_n) begin : core
        logic [7:0] r;
        if (!rst_n || !sar_run) begin
            core_cnt <= 0;
            sar_done <= 1'b0;
            if (core_rand) core_delay <= $urandom_range(0, 12);
        end else if (core_en && !sar_done) begin
            if (core_cnt == core_delay) begin
                r = 8'($urandom);
                sar_result <= r;
                sar_done <= 1'b1;
                core_q.push_back(int'(r));
            end else core_cnt <= core_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_if.valid && res_if.ready) begin
                got_ch.push_back(int'(res_if.ch));
                got_data.push_back(int'(res_if.data));
            end
            if (sample) srun++;
            else if (srun != 0) begin
                sample_runs.push_back(srun);
                srun = 0;
            end
            if (sar_run && !run_prev) run_starts++;
            run_prev = sar_run;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_ch.delete();
        got_data.delete();
        core_q.delete();
        sample_runs.delete();
    endtask

    task automatic do_start(input logic [NCH-1:0] m);
        ch_mask = m;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_idle(input int max, input bit rand_ready, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            if (rand_ready) res_if.ready = 1'($urandom_range(0, 1));
            tick();
        end
        res_if.ready = 1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({sar_run, sample, busy, err_timeout, res_if.valid, ch_sel, res_if.ch, res_if.data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got run=%b smp=%b busy=%b err=%b vld=%b ch=%0d rch=%0d data=%0d expected all 0",
                     sar_run, sample, busy, err_timeout, res_if.valid, ch_sel, res_if.ch, res_if.data);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        ena = 1;
        tick();
        n_cmp++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_sweep();
        int exp_q[$];
        bit ok;
        clear_q();
        core_rand = 0;
        core_delay = 9;
        for (int i = 0; i < NCH; i++) if (i == 0 || i == 2) exp_q.push_back(i);
        do_start(4'b0101);
        n_cmp++;
        if (sample !== 1 || ch_sel !== 0) begin
            n_fail++;
            $display("FAIL t1_first_sample: got sample=%b ch_sel=%0d expected 1/0", sample, ch_sel);
        end
        wait_idle(400, 0, ok);
        n_cmp++;
        if (!ok || got_ch.size() != 2) begin
            n_fail++;
            $display("FAIL t1_done: got idle=%0d results=%0d expected 1/2", ok, got_ch.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_ch.size() || i >= core_q.size() || got_ch[i] != exp_q[i] || got_data[i] != core_q[i]) begin
                n_fail++;
                $display("FAIL t1_result[%0d]: got ch=%0d data=%0d expected ch=%0d data=%0d", i,
                         i < got_ch.size() ? got_ch[i] : -1, i < got_data.size() ? got_data[i] : -1,
                         exp_q[i], i < core_q.size() ? core_q[i] : -1);
            end
        end
        n_cmp++;
        if (sample_runs.size() != 2 || sample_runs[0] != SAMPLE_CYC || sample_runs[1] != SAMPLE_CYC) begin
            n_fail++;
            $display("FAIL t1_sample_len: got %0d runs first=%0d expected 2 runs of %0d", sample_runs.size(),
                     sample_runs.size() > 0 ? sample_runs[0] : -1, SAMPLE_CYC);
        end
    endtask

    task automatic test_random_sweeps();
        bit ok;
        core_rand = 1;
        for (int it = 0; it < 8; it++) begin
            int exp_q[$];
            logic [NCH-1:0] m;
            clear_q();
            m = NCH'($urandom_range(1, 15));
            for (int i = 0; i < NCH; i++) if (m[i]) exp_q.push_back(i);
            do_start(m);
            ch_mask = NCH'($urandom);
            wait_idle(2000, 1, ok);
            n_cmp++;
            if (!ok || got_ch.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_count: mask=%b got idle=%0d results=%0d expected 1/%0d", it, m, ok,
                         got_ch.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (i >= got_ch.size() || i >= core_q.size() || got_ch[i] != exp_q[i] || got_data[i] != core_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_result[%0d]: got ch=%0d data=%0d expected ch=%0d data=%0d", it, i,
                             i < got_ch.size() ? got_ch[i] : -1, i < got_data.size() ? got_data[i] : -1,
                             exp_q[i], i < core_q.size() ? core_q[i] : -1);
                end
            end
            n_cmp++;
            if (sample_runs.size() != exp_q.size() || (sample_runs.size() > 0 && sample_runs.min() != '{SAMPLE_CYC})
                || (sample_runs.size() > 0 && sample_runs.max() != '{SAMPLE_CYC})) begin
                n_fail++;
                $display("FAIL rnd%0d_sample_len: got %0d runs expected %0d runs of %0d", it, sample_runs.size(),
                         exp_q.size(), SAMPLE_CYC);
            end
        end
        core_rand = 0;
    endtask

    task automatic test_backpressure();
        bit ok = 0;
        logic [7:0] d0;
        logic [CHW-1:0] c0;
        clear_q();
        core_delay = 3;
        res_if.ready = 0;
        do_start(4'b0101);
        for (int i = 0; i < 100; i++) begin
            if (res_if.valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        d0 = res_if.data;
        c0 = res_if.ch;
        n_cmp++;
        if (!ok || c0 !== 0 || core_q.size() != 1 || int'(d0) != core_q[0]) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%0d ch=%0d data=%0d expected 1/0/%0d", ok, c0, d0,
                     core_q.size() > 0 ? core_q[0] : -1);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (res_if.valid !== 1 || res_if.data !== d0 || res_if.ch !== c0 || sample !== 0 || sar_run !== 0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0d ch=%0d sample=%b run=%b expected 1/%0d/%0d/0/0",
                         i, res_if.valid, res_if.data, res_if.ch, sample, sar_run, d0, c0);
            end
        end
        res_if.ready = 1;
        wait_idle(400, 0, ok);
        n_cmp++;
        if (!ok || got_ch.size() != 2 || got_ch[1] != 2) begin
            n_fail++;
            $display("FAIL bp_finish: got idle=%0d results=%0d expected 1/2 ending on ch2", ok, got_ch.size());
        end
    endtask

    task automatic test_continuous();
        bit ok;
        int n0, w = 0;
        clear_q();
        core_delay = 5;
        continuous = 1;
        do_start(4'b1000);
        while (got_ch.size() < 3 && w < 500) begin
            tick();
            w++;
        end
        while (!sar_run && w < 600) begin
            tick();
            w++;
        end
        n_cmp++;
        if (w >= 600) begin
            n_fail++;
            $display("FAIL cont_progress: got %0d results expected at least 3 and a running conversion", got_ch.size());
        end
        continuous = 0;
        n0 = got_ch.size();
        wait_idle(400, 0, ok);
        n_cmp++;
        if (!ok || got_ch.size() != n0 + 1) begin
            n_fail++;
            $display("FAIL cont_stop: got idle=%0d results=%0d expected 1/%0d", ok, got_ch.size(), n0 + 1);
        end
        for (int i = 0; i < got_ch.size(); i++) begin
            n_cmp++;
            if (got_ch[i] != 3 || i >= core_q.size() || got_data[i] != core_q[i]) begin
                n_fail++;
                $display("FAIL cont_result[%0d]: got ch=%0d data=%0d expected ch=3 data=%0d", i, got_ch[i],
                         got_data[i], i < core_q.size() ? core_q[i] : -1);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int w = 0, n = 0;
        clear_q();
        core_en = 0;
        do_start(NCH'($urandom_range(1, 15)));
        while (!sar_run && w < 50) begin
            tick();
            w++;
        end
        while (sar_run && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != TIMEOUT || err_timeout !== 1 || busy !== 0 || sar_run !== 0 || got_ch.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: got run_cycles=%0d err=%b busy=%b run=%b results=%0d expected %0d/1/0/0/0",
                     n, err_timeout, busy, sar_run, got_ch.size(), TIMEOUT);
        end
        repeat (3) tick();
        n_cmp++;
        if (err_timeout !== 1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
        end
        core_en = 1;
        core_delay = 2;
        do_start(4'b0001);
        n_cmp++;
        if (err_timeout !== 0 || busy !== 1) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b busy=%b expected 0/1", err_timeout, busy);
        end
        wait_idle(200, 0, ok);
        n_cmp++;
        if (!ok || got_ch.size() != 1 || err_timeout !== 0) begin
            n_fail++;
            $display("FAIL timeout_recover: got idle=%0d results=%0d err=%b expected 1/1/0", ok, got_ch.size(),
                     err_timeout);
        end
    endtask

    task automatic test_async_reset();
        int w = 0;
        clear_q();
        core_delay = 12;
        do_start(4'b0010);
        while (!sar_run && w < 50) begin
            tick();
            w++;
        end
        tick();
        tick();
        #3 rst_n = 0;
        #1;
        n_cmp++;
        if ({sar_run, sample, res_if.valid, busy} !== 4'b0000 || w >= 50) begin
            n_fail++;
            $display("FAIL async_reset: got run=%b sample=%b valid=%b busy=%b reached=%0d expected 0/0/0/0/1",
                     sar_run, sample, res_if.valid, busy, w < 50);
        end
        #2 rst_n = 1;
        tick();
        do_start('0);
        repeat (5) tick();
        n_cmp++;
        if (busy !== 0 || got_ch.size() != 0) begin
            n_fail++;
            $display("FAIL zero_mask_start: got busy=%b results=%0d expected 0/0", busy, got_ch.size());
        end
    endtask

    task automatic test_ena_abort();
        int rs;
        clear_q();
        core_delay = 3;
        do_start(4'b0110);
        tick();
        ena = 0;
        tick();
        n_cmp++;
        if (busy !== 0 || sample !== 0 || sar_run !== 0) begin
            n_fail++;
            $display("FAIL ena_abort: got busy=%b sample=%b run=%b expected 0/0/0", busy, sample, sar_run);
        end
        rs = run_starts;
        ena = 1;
        repeat (30) tick();
        n_cmp++;
        if (run_starts != rs || got_ch.size() != 0 || busy !== 0) begin
            n_fail++;
            $display("FAIL ena_no_result: got runs=%0d results=%0d busy=%b expected %0d/0/0", run_starts,
                     got_ch.size(), busy, rs);
        end
        ena = 0;
        do_start(4'b1111);
        tick();
        n_cmp++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL ena_low_start: got busy=%b expected 0", busy);
        end
        ena = 1;
        tick();
    endtask

    initial begin
        res_if.ready = 1;
        test_reset();
        test_single_sweep();
        test_backpressure();
        test_random_sweeps();
        test_continuous();
        test_timeout();
        test_async_reset();
        test_ena_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
